// File: rtl/shared_mem_ctrl_pkg.sv
// rtl/shared_mem_ctrl_pkg.sv - shared memory controller width codes, state enum and lane helpers
package shared_mem_ctrl_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;
  localparam logic [1:0] WIDTH_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reserved width or a lane offset that is not naturally aligned faults the access
  function automatic logic access_fault(input logic [1:0] width, input logic [1:0] off);
    case (width)
      WIDTH_BYTE: access_fault = 1'b0;
      WIDTH_HALF: access_fault = off[0];
      WIDTH_WORD: access_fault = |off;
      WIDTH_RSVD: access_fault = 1'b1;
    endcase
  endfunction

  // Byte-lane write enables for a store of the given width at the given offset
  function automatic logic [3:0] lane_enables(input logic [1:0] width, input logic [1:0] off);
    case (width)
      WIDTH_BYTE: lane_enables = 4'b0001 << off;
      WIDTH_HALF: lane_enables = 4'b0011 << off;
      WIDTH_WORD: lane_enables = 4'b1111;
      WIDTH_RSVD: lane_enables = 4'b0000;
    endcase
  endfunction

  // Pick the addressed lane(s) out of a word and sign/zero extend to 32 bits
  function automatic logic [31:0] lane_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] width, input logic usign);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (width)
      WIDTH_BYTE: lane_extend = {{24{~usign & b[7]}}, b};
      WIDTH_HALF: lane_extend = {{16{~usign & h[15]}}, h};
      WIDTH_WORD: lane_extend = word;
      WIDTH_RSVD: lane_extend = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/shared_mem_ctrl_arb.sv
// rtl/shared_mem_ctrl_arb.sv - round-robin / fixed-priority requester arbiter
module shared_mem_ctrl_arb #(
  parameter int N    = 2,
  parameter int MODE = 0,
  localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  // Fixed-priority mode never looks at the rotating pointer
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Scan from the pointer upward (round-robin) or from the top index down (fixed priority)
  always_comb begin
    logic found;
    int   cand;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      if (MODE == 1) cand = N - 1 - k;
      else           cand = (int'(ptr_i) + k) % N;
      if (!found && req_i[IW'(cand)]) begin
        found = 1'b1;
        idx_o = IW'(cand);
      end
    end
  end

  // One-hot view of the winner, empty when nobody requests
  always_comb begin
    gnt_o = '0;
    if (|req_i) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/shared_mem_ctrl.sv
// rtl/shared_mem_ctrl.sv - single-ported unified memory shared by several requesters
module shared_mem_ctrl
  import shared_mem_ctrl_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int DEPTH    = 1 << 16,
  parameter int LATENCY  = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NPORTS-1:0]    req_i,
  input  logic [NPORTS-1:0]    we_i,
  input  logic [32*NPORTS-1:0] addr_i,
  input  logic [2*NPORTS-1:0]  width_i,
  input  logic [NPORTS-1:0]    usignext_i,
  input  logic [32*NPORTS-1:0] wdata_i,
  output logic [32*NPORTS-1:0] rdata_o,
  output logic [NPORTS-1:0]    ready_o,
  output logic [NPORTS-1:0]    err_o,
  output logic                 busy_o
);

  localparam int         AW  = $clog2(DEPTH);
  localparam int         IW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);

  state_e                state_q, state_d;
  logic [IW-1:0]         gnt_q, ptr_q, arb_idx;
  logic [NPORTS-1:0]     arb_gnt;
  logic                  we_q, usign_q;
  logic [1:0]            width_q;
  logic [31:0]           addr_q, wdata_q;
  logic [3:0]            cnt_q;
  logic [31:0]           mem [DEPTH];
  logic [AW-1:0]         widx;
  logic [1:0]            off;
  logic                  fault;
  logic [3:0]            be;
  logic [31:0]           wlane;
  logic [NPORTS-1:0]     ready_d, ready_q, err_d, err_q;
  logic [32*NPORTS-1:0]  rdata_d, rdata_q;
  logic                  unused_addr_hi;

  shared_mem_ctrl_arb #(.N(NPORTS), .MODE(ARB_MODE)) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Address bits above the array size wrap, so they are simply dropped
  assign widx           = addr_q[AW+1:2];
  assign off            = addr_q[1:0];
  assign unused_addr_hi = ^addr_q[31:AW+2];
  assign fault          = access_fault(width_q, off);
  assign wlane          = wdata_q << {off, 3'b000};

  assign busy_o  = (state_q != ST_IDLE);
  assign ready_o = ready_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

  // State register; reset aborts whatever is in flight
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: arbitrate in IDLE, count wait states, complete in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|arb_gnt) state_d = (LAT == 4'd0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd1) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Completion: lane enables for stores, extended read data and ready/err for the granted port
  always_comb begin
    ready_d = '0;
    err_d   = '0;
    rdata_d = '0;
    be      = 4'b0000;
    if (state_q == ST_DONE) begin
      ready_d[gnt_q] = 1'b1;
      err_d[gnt_q]   = fault;
      if (!fault) begin
        if (we_q) be = lane_enables(width_q, off);
        else      rdata_d[32*gnt_q +: 32] = lane_extend(mem[widx], off, width_q, usign_q);
      end
    end
  end

  // Latch the granted request, advance the pointer, run the wait counter, register outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      gnt_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      usign_q <= 1'b0;
      width_q <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 4'd0;
      ready_q <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (state_q == ST_IDLE && |arb_gnt) begin
        gnt_q   <= arb_idx;
        ptr_q   <= (int'(arb_idx) == NPORTS - 1) ? '0 : arb_idx + 1'b1;
        we_q    <= we_i[arb_idx];
        usign_q <= usignext_i[arb_idx];
        width_q <= width_i[2*arb_idx +: 2];
        addr_q  <= addr_i[32*arb_idx +: 32];
        wdata_q <= wdata_i[32*arb_idx +: 32];
        cnt_q   <= LAT;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Byte-lane array write; contents are deliberately not cleared by reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// tb/tb_shared_mem_ctrl.sv - self-checking bench for shared_mem_ctrl
module tb_shared_mem_ctrl;

  localparam int DEPTH = 1024;
  localparam logic [1:0] WB = 2'b00, WH = 2'b01, WW = 2'b10, WR = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic [1:0]  req_s   [2];
  logic [1:0]  we_s    [2];
  logic [1:0]  us_s    [2];
  logic [63:0] addr_s  [2];
  logic [63:0] wdata_s [2];
  logic [3:0]  width_s [2];
  logic [63:0] rdata_s [2];
  logic [1:0]  ready_s [2];
  logic [1:0]  err_s   [2];
  logic        busy_s  [2];

  shared_mem_ctrl #(.NPORTS(2), .DEPTH(DEPTH), .LATENCY(1), .ARB_MODE(0)) u_rr (
    .clk_i(clk), .reset_i(rst_s[0]), .req_i(req_s[0]), .we_i(we_s[0]), .addr_i(addr_s[0]),
    .width_i(width_s[0]), .usignext_i(us_s[0]), .wdata_i(wdata_s[0]), .rdata_o(rdata_s[0]),
    .ready_o(ready_s[0]), .err_o(err_s[0]), .busy_o(busy_s[0])
  );

  shared_mem_ctrl #(.NPORTS(2), .DEPTH(DEPTH), .LATENCY(4), .ARB_MODE(1)) u_fp (
    .clk_i(clk), .reset_i(rst_s[1]), .req_i(req_s[1]), .we_i(we_s[1]), .addr_i(addr_s[1]),
    .width_i(width_s[1]), .usignext_i(us_s[1]), .wdata_i(wdata_s[1]), .rdata_o(rdata_s[1]),
    .ready_o(ready_s[1]), .err_o(err_s[1]), .busy_o(busy_s[1])
  );

  typedef struct {
    int          p;
    logic        w;
    logic [31:0] a;
    logic [1:0]  wd;
    logic        u;
    logic [31:0] dat;
    logic [31:0] erd;
    logic        ee;
  } vec_t;

  logic [7:0] mem_m [2][4*DEPTH];
  int         lat_m [2] = '{1, 4};
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Byte-addressed reference memory; returns what a port should see for one access
  function automatic void model(input int d, input logic w, input logic [31:0] a, input logic [1:0] wd,
                                input logic u, input logic [31:0] dat,
                                output logic [31:0] rd, output logic e);
    int base, n;
    logic [31:0] v;
    base = int'(a % (4 * DEPTH));
    n = (wd == WB) ? 1 : (wd == WH) ? 2 : 4;
    e = (wd == WR) || (base % n != 0);
    rd = 32'h0;
    v = 32'h0;
    if (!e) begin
      for (int b = 0; b < n; b++) begin
        if (w) mem_m[d][base+b] = dat[8*b +: 8];
        else   v = v | (32'(mem_m[d][base+b]) << (8*b));
      end
      if (!w) begin
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endfunction

  task automatic wait_ready(input int d, output int cyc, output logic [1:0] r);
    cyc = 0;
    r = 2'b00;
    while (r == 2'b00 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      r = ready_s[d];
    end
  endtask

  task automatic access(input int d, input int p, input logic w, input logic [31:0] a, input logic [1:0] wd,
                        input logic u, input logic [31:0] dat,
                        output logic [31:0] rd, output logic e, output int cyc, output logic [1:0] r);
    @(negedge clk);
    req_s[d] = 2'b00;
    req_s[d][p] = 1'b1;
    we_s[d][p] = w;
    us_s[d][p] = u;
    addr_s[d][32*p +: 32] = a;
    wdata_s[d][32*p +: 32] = dat;
    width_s[d][2*p +: 2] = wd;
    wait_ready(d, cyc, r);
    rd = rdata_s[d][32*p +: 32];
    e = err_s[d][p];
    req_s[d] = 2'b00;
  endtask

  task automatic run(input int d, input int p, input logic w, input logic [31:0] a, input logic [1:0] wd,
                     input logic u, input logic [31:0] dat, input string nm);
    logic [31:0] erd, rd;
    logic ee, e;
    logic [1:0] r, er;
    int cyc;
    model(d, w, a, wd, u, dat, erd, ee);
    access(d, p, w, a, wd, u, dat, rd, e, cyc, r);
    er = 2'b00;
    er[p] = 1'b1;
    check({nm, " ready"}, 64'(r), 64'(er));
    check({nm, " latency"}, 64'(cyc), 64'(lat_m[d] + 2));
    check({nm, " err"}, 64'(e), 64'(ee));
    check({nm, " rdata"}, 64'(rd), 64'(erd));
  endtask

  initial begin
    vec_t tbl[18];
    logic [31:0] erd, rd;
    logic ee, e;
    logic [1:0] r, er;
    int cyc, pulses, exp_g;

    tbl[0]  = '{1, 1'b1, 32'h100,  WW, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1, 1'b0, 32'h100,  WW, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1, 1'b1, 32'h100,  WW, 1'b0, 32'h80FF7F00, 32'h0,        1'b0};
    tbl[3]  = '{1, 1'b0, 32'h101,  WB, 1'b0, 32'h0,        32'h0000007F, 1'b0};
    tbl[4]  = '{1, 1'b0, 32'h103,  WB, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0};
    tbl[5]  = '{1, 1'b0, 32'h103,  WB, 1'b1, 32'h0,        32'h00000080, 1'b0};
    tbl[6]  = '{1, 1'b0, 32'h102,  WH, 1'b0, 32'h0,        32'hFFFF80FF, 1'b0};
    tbl[7]  = '{1, 1'b0, 32'h102,  WW, 1'b0, 32'h0,        32'h0,        1'b1};
    tbl[8]  = '{1, 1'b1, 32'h101,  WH, 1'b0, 32'h00001234, 32'h0,        1'b1};
    tbl[9]  = '{1, 1'b0, 32'h100,  WW, 1'b0, 32'h0,        32'h80FF7F00, 1'b0};
    tbl[10] = '{0, 1'b1, 32'h102,  WB, 1'b0, 32'h123456AA, 32'h0,        1'b0};
    tbl[11] = '{0, 1'b0, 32'h100,  WW, 1'b0, 32'h0,        32'h80AA7F00, 1'b0};
    tbl[12] = '{0, 1'b1, 32'h102,  WH, 1'b0, 32'hABCD5566, 32'h0,        1'b0};
    tbl[13] = '{0, 1'b0, 32'h102,  WH, 1'b1, 32'h0,        32'h00005566, 1'b0};
    tbl[14] = '{0, 1'b0, 32'h100,  WR, 1'b0, 32'h0,        32'h0,        1'b1};
    tbl[15] = '{1, 1'b1, 32'h1100, WW, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0};
    tbl[16] = '{1, 1'b0, 32'h100,  WW, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0};
    tbl[17] = '{0, 1'b0, 32'h100,  WB, 1'b0, 32'h0,        32'h0000000D, 1'b0};

    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b0;
      req_s[d] = 2'b00;
      we_s[d] = 2'b00;
      us_s[d] = 2'b00;
      addr_s[d] = 64'h0;
      wdata_s[d] = 64'h0;
      width_s[d] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset ready", 64'(ready_s[d]), 64'h0);
      check("reset err", 64'(err_s[d]), 64'h0);
      check("reset rdata", rdata_s[d], 64'h0);
      check("reset busy", 64'(busy_s[d]), 64'h0);
    end
    @(negedge clk);
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;

    // Directed vectors on the round-robin instance
    for (int i = 0; i < 18; i++) begin
      model(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].u, tbl[i].dat, erd, ee);
      access(0, tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].u, tbl[i].dat, rd, e, cyc, r);
      er = 2'b00;
      er[tbl[i].p] = 1'b1;
      check($sformatf("vec%0d ready", i), 64'(r), 64'(er));
      check($sformatf("vec%0d latency", i), 64'(cyc), 64'd3);
      check($sformatf("vec%0d rdata", i), 64'(rd), 64'(tbl[i].erd));
      check($sformatf("vec%0d err", i), 64'(e), 64'(tbl[i].ee));
    end

    // Randomized accesses against the reference model
    for (int i = 0; i < 16; i++)
      run(0, i % 2, 1'b1, 32'h200 + 32'(4 * i), WW, 1'b0, $urandom, "init");
    for (int i = 0; i < 200; i++)
      run(0, $urandom_range(0, 1), 1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 63)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, "rand");

    // Requester drops req right after it is sampled: access still completes
    model(0, 1'b0, 32'h100, WW, 1'b0, 32'h0, erd, ee);
    @(negedge clk);
    req_s[0] = 2'b01;
    we_s[0] = 2'b00;
    addr_s[0][31:0] = 32'h100;
    width_s[0][1:0] = WW;
    @(posedge clk);
    #1;
    req_s[0] = 2'b00;
    check("drop busy", 64'(busy_s[0]), 64'h1);
    wait_ready(0, cyc, r);
    check("drop ready", 64'(r), 64'h1);
    check("drop latency", 64'(cyc + 1), 64'd3);
    check("drop rdata", 64'(rdata_s[0][31:0]), 64'(erd));

    // Round-robin alternation with both ports requesting continuously after a fresh reset
    @(negedge clk);
    rst_s[0] = 1'b0;
    @(negedge clk);
    rst_s[0] = 1'b1;
    @(negedge clk);
    req_s[0] = 2'b11;
    we_s[0] = 2'b00;
    addr_s[0] = {32'h200, 32'h100};
    width_s[0] = {WW, WW};
    exp_g = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ready(0, cyc, r);
      er = 2'b00;
      er[exp_g] = 1'b1;
      model(0, 1'b0, (exp_g == 0) ? 32'h100 : 32'h200, WW, 1'b0, 32'h0, erd, ee);
      check($sformatf("rr grant%0d", k), 64'(r), 64'(er));
      check($sformatf("rr spacing%0d", k), 64'(cyc), 64'd3);
      check($sformatf("rr rdata%0d", k), 64'(rdata_s[0][32*exp_g +: 32]), 64'(erd));
      exp_g = (exp_g + 1) % 2;
    end
    req_s[0] = 2'b00;

    // Fixed priority with LATENCY=4: port 1 starves port 0 while it keeps requesting
    run(1, 1, 1'b1, 32'h100, WW, 1'b0, 32'h11111111, "fp init");
    model(1, 1'b0, 32'h100, WW, 1'b0, 32'h0, erd, ee);
    @(negedge clk);
    req_s[1] = 2'b11;
    we_s[1] = 2'b00;
    addr_s[1] = {32'h100, 32'h100};
    width_s[1] = {WW, WW};
    for (int k = 0; k < 3; k++) begin
      wait_ready(1, cyc, r);
      check("fp grant p1", 64'(r), 64'h2);
      check("fp spacing", 64'(cyc), 64'd6);
      check("fp rdata p1", 64'(rdata_s[1][63:32]), 64'(erd));
    end
    req_s[1] = 2'b01;
    wait_ready(1, cyc, r);
    check("fp grant p0", 64'(r), 64'h1);
    check("fp p0 spacing", 64'(cyc), 64'd6);
    check("fp rdata p0", 64'(rdata_s[1][31:0]), 64'(erd));
    req_s[1] = 2'b00;

    // Reset during the wait states of a store aborts it
    @(negedge clk);
    req_s[1] = 2'b01;
    we_s[1] = 2'b01;
    addr_s[1][31:0] = 32'h100;
    width_s[1][1:0] = WW;
    wdata_s[1][31:0] = 32'h22222222;
    repeat (3) @(posedge clk);
    #1;
    check("abort busy before", 64'(busy_s[1]), 64'h1);
    @(negedge clk);
    rst_s[1] = 1'b0;
    #1;
    check("abort busy", 64'(busy_s[1]), 64'h0);
    check("abort ready", 64'(ready_s[1]), 64'h0);
    check("abort rdata", rdata_s[1], 64'h0);
    req_s[1] = 2'b00;
    we_s[1] = 2'b00;
    repeat (2) @(negedge clk);
    rst_s[1] = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ready_s[1] != 2'b00) pulses++;
    end
    check("abort no ready", 64'(pulses), 64'h0);
    run(1, 0, 1'b0, 32'h100, WW, 1'b0, 32'h0, "abort readback");
    run(1, 0, 1'b1, 32'h100 + 32'(4 * DEPTH), WW, 1'b0, 32'h33333333, "alias store");
    run(1, 1, 1'b0, 32'h100, WW, 1'b0, 32'h0, "alias load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
